// File: rtl/ysyx_22051468_issue_ctrl.sv
// ID/EX issue controller: one-entry issue slot, long-latency register scoreboard,
// mul/div occupancy, outstanding-op limit, flush rollback and stall accounting.
module ysyx_22051468_issue_ctrl #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rs1_need_i,
  input  logic        rs2_need_i,
  input  logic        rd_need_i,
  input  logic        is_load_i,
  input  logic        is_mul_i,
  input  logic        is_div_i,
  input  logic        is_rem_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [4:0]  issue_rd_o,
  output logic        issue_long_o,
  output logic        issue_md_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        md_done_i,
  input  logic        flush_i,
  output logic [1:0]  stall_cause_o,
  output logic [31:0] stall_cnt_o,
  output logic        err_o
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high. id_ready_o never looks at id_valid_i; issue_valid_o never looks
  // at issue_ready_i. flush_i overrides both: nothing is captured and the slot
  // is dropped even if EX shows ready.

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_DATA = 2'd1,
    CAUSE_MD   = 2'd2,
    CAUSE_FULL = 2'd3
  } cause_e;

  localparam logic [3:0] LP_MAX = 4'(MAX_OUTST);

  logic [31:0] r_busy;
  logic [3:0]  r_outst;
  logic        r_md_busy;
  logic        r_slot_valid;
  logic [4:0]  r_slot_rd;
  logic        r_slot_long;
  logic        r_slot_md;
  logic [31:0] r_stall_cnt;
  logic        r_err;

  logic        w_long_i;
  logic        w_md_i;
  logic        w_hazard;
  logic        w_md_stall;
  logic        w_full_stall;
  logic        w_slot_free;
  logic        w_capture;
  logic        w_cap_long;
  logic        w_cap_md;
  logic        w_rb_long;
  logic        w_rb_md;
  logic        w_wb_ok;
  logic        w_wb_err;
  logic        w_md_done_ok;
  logic        w_md_done_err;
  logic        w_stall_cycle;
  logic [31:0] w_busy_nxt;
  logic [3:0]  w_outst_nxt;
  logic        w_md_busy_nxt;
  cause_e      w_cause;

  assign w_long_i = (is_load_i | is_mul_i | is_div_i | is_rem_i) & rd_need_i & (rd_addr_i != 5'd0);
  assign w_md_i   = is_mul_i | is_div_i | is_rem_i;

  // Hazards look at registered busy only; a writeback releases dependents next cycle.
  assign w_hazard = (rs1_need_i & (rs1_addr_i != 5'd0) & r_busy[rs1_addr_i])
                  | (rs2_need_i & (rs2_addr_i != 5'd0) & r_busy[rs2_addr_i])
                  | (rd_need_i  & (rd_addr_i  != 5'd0) & r_busy[rd_addr_i]);

  assign w_md_stall   = w_md_i & r_md_busy;
  assign w_full_stall = w_long_i & (r_outst == LP_MAX);
  assign w_slot_free  = ~r_slot_valid | issue_ready_i;

  assign id_ready_o = ~flush_i & ~w_hazard & ~w_md_stall & ~w_full_stall & w_slot_free;
  assign w_capture  = id_valid_i & id_ready_o;
  assign w_cap_long = w_capture & w_long_i;
  assign w_cap_md   = w_capture & w_md_i;

  assign w_rb_long = flush_i & r_slot_valid & r_slot_long;
  assign w_rb_md   = flush_i & r_slot_valid & r_slot_md;

  // A writeback that matches no tracked op is flagged and otherwise ignored.
  assign w_wb_ok       = wb_valid_i & (r_outst != 4'd0) & r_busy[wb_rd_i];
  assign w_wb_err      = wb_valid_i & ~w_wb_ok;
  assign w_md_done_ok  = md_done_i & r_md_busy;
  assign w_md_done_err = md_done_i & ~r_md_busy;

  assign w_stall_cycle = id_valid_i & ~id_ready_o & ~flush_i;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_ok) begin
      w_busy_nxt[wb_rd_i] = 1'b0;
    end
    if (w_rb_long) begin
      w_busy_nxt[r_slot_rd] = 1'b0;
    end
    if (w_cap_long) begin
      w_busy_nxt[rd_addr_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  assign w_outst_nxt = r_outst + {3'd0, w_cap_long} - {3'd0, w_rb_long} - {3'd0, w_wb_ok};
  assign w_md_busy_nxt = w_cap_md | (r_md_busy & ~w_md_done_ok & ~w_rb_md);

  always_comb begin
    w_cause = CAUSE_NONE;
    if (id_valid_i) begin
      if (w_hazard) begin
        w_cause = CAUSE_DATA;
      end else if (w_md_stall) begin
        w_cause = CAUSE_MD;
      end else if (w_full_stall) begin
        w_cause = CAUSE_FULL;
      end
    end
  end

  assign stall_cause_o = w_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_outst   <= '0;
      r_md_busy <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_outst   <= w_outst_nxt;
      r_md_busy <= w_md_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_slot_rd    <= '0;
      r_slot_long  <= 1'b0;
      r_slot_md    <= 1'b0;
    end else if (w_capture) begin
      r_slot_valid <= 1'b1;
      r_slot_rd    <= rd_addr_i;
      r_slot_long  <= w_long_i;
      r_slot_md    <= w_md_i;
    end else if (flush_i | (r_slot_valid & issue_ready_i)) begin
      r_slot_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_stall_cycle && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_wb_err | w_md_done_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign issue_valid_o = r_slot_valid;
  assign issue_rd_o    = r_slot_rd;
  assign issue_long_o  = r_slot_long;
  assign issue_md_o    = r_slot_md;
  assign stall_cnt_o   = r_stall_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ysyx_22051468_issue_ctrl.sv
// Bench for the issue controller: directed scenarios plus random traffic, all
// checked against a scoreboard model built from the issue/hazard rules.
module tb_ysyx_22051468_issue_ctrl;

  localparam int MAX_OUTST = 4;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_need;
    logic       rs2_need;
    logic       rd_need;
    logic       is_load;
    logic       is_mul;
    logic       is_div;
    logic       is_rem;
    logic       issue_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       md_done;
    logic       flush;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid_i, id_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        rs1_need_i, rs2_need_i, rd_need_i;
  logic        is_load_i, is_mul_i, is_div_i, is_rem_i;
  logic        issue_valid_o, issue_ready_i;
  logic [4:0]  issue_rd_o;
  logic        issue_long_o, issue_md_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        md_done_i, flush_i;
  logic [1:0]  stall_cause_o;
  logic [31:0] stall_cnt_o;
  logic        err_o;

  ysyx_22051468_issue_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_need_i(rs1_need_i), .rs2_need_i(rs2_need_i), .rd_need_i(rd_need_i),
    .is_load_i(is_load_i), .is_mul_i(is_mul_i), .is_div_i(is_div_i), .is_rem_i(is_rem_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_rd_o(issue_rd_o), .issue_long_o(issue_long_o), .issue_md_o(issue_md_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .md_done_i(md_done_i), .flush_i(flush_i),
    .stall_cause_o(stall_cause_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_busy;
  int          m_outst;
  bit          m_md_busy;
  bit          m_slot_v;
  logic [4:0]  m_slot_rd;
  bit          m_slot_long;
  bit          m_slot_md;
  logic [31:0] m_stall_cnt;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_outst = 0; m_md_busy = 0;
    m_slot_v = 0; m_slot_rd = '0; m_slot_long = 0; m_slot_md = 0;
    m_stall_cnt = '0; m_err = 0;
  endtask

  function automatic bit is_long(input stim_t s);
    return (s.is_load || s.is_mul || s.is_div || s.is_rem) && s.rd_need && s.rd != 0;
  endfunction

  function automatic bit is_md(input stim_t s);
    return s.is_mul || s.is_div || s.is_rem;
  endfunction

  function automatic void model_comb(input stim_t s, output bit rdy, output logic [1:0] cause);
    bit haz, mds, full;
    haz  = (s.rs1_need && s.rs1 != 0 && m_busy[s.rs1]) ||
           (s.rs2_need && s.rs2 != 0 && m_busy[s.rs2]) ||
           (s.rd_need  && s.rd  != 0 && m_busy[s.rd]);
    mds  = is_md(s) && m_md_busy;
    full = is_long(s) && m_outst == MAX_OUTST;
    cause = !s.id_valid ? 2'd0 : haz ? 2'd1 : mds ? 2'd2 : full ? 2'd3 : 2'd0;
    rdy = !s.flush && !haz && !mds && !full && (!m_slot_v || s.issue_ready);
  endfunction

  task automatic model_update(input stim_t s);
    bit rdy, cap;
    logic [1:0] cause;
    logic [31:0] nb;
    int no;
    bit nmd;
    model_comb(s, rdy, cause);
    cap = s.id_valid && rdy;
    nb = m_busy; no = m_outst; nmd = m_md_busy;
    if (s.wb_valid) begin
      if (m_outst == 0 || !m_busy[s.wb_rd]) m_err = 1;
      else begin nb[s.wb_rd] = 0; no--; end
    end
    if (s.flush && m_slot_v) begin
      if (m_slot_long) begin nb[m_slot_rd] = 0; no--; end
      if (m_slot_md) nmd = 0;
    end
    if (s.md_done) begin
      if (!m_md_busy) m_err = 1;
      else nmd = 0;
    end
    if (s.id_valid && !rdy && !s.flush && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (cap) begin
      if (is_long(s)) begin nb[s.rd] = 1; no++; end
      if (is_md(s)) nmd = 1;
      m_slot_v = 1; m_slot_rd = s.rd; m_slot_long = is_long(s); m_slot_md = is_md(s);
    end else if (s.flush || (m_slot_v && s.issue_ready)) begin
      m_slot_v = 0;
    end
    m_busy = nb; m_outst = no; m_md_busy = nmd;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    id_valid_i = s.id_valid; rs1_addr_i = s.rs1; rs2_addr_i = s.rs2; rd_addr_i = s.rd;
    rs1_need_i = s.rs1_need; rs2_need_i = s.rs2_need; rd_need_i = s.rd_need;
    is_load_i = s.is_load; is_mul_i = s.is_mul; is_div_i = s.is_div; is_rem_i = s.is_rem;
    issue_ready_i = s.issue_ready; wb_valid_i = s.wb_valid; wb_rd_i = s.wb_rd;
    md_done_i = s.md_done; flush_i = s.flush;
  endtask

  task automatic check_regs();
    check("issue_valid", 32'(issue_valid_o), 32'(m_slot_v));
    if (m_slot_v) begin
      check("issue_rd", 32'(issue_rd_o), 32'(m_slot_rd));
      check("issue_long", 32'(issue_long_o), 32'(m_slot_long));
      check("issue_md", 32'(issue_md_o), 32'(m_slot_md));
    end
    check("stall_cnt", stall_cnt_o, m_stall_cnt);
    check("err", 32'(err_o), 32'(m_err));
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check state.
  task automatic step(input stim_t s);
    bit rdy;
    logic [1:0] cause;
    @(negedge clk);
    drive(s);
    #1;
    model_comb(s, rdy, cause);
    check("id_ready", 32'(id_ready_o), 32'(rdy));
    check("stall_cause", 32'(stall_cause_o), 32'(cause));
    @(posedge clk);
    model_update(s);
    #1;
    check_regs();
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.issue_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s = idle();
    s.id_valid = 1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.rd_need = 1; s.rs1_need = 1; s.rs2_need = 1;
    return s;
  endfunction

  function automatic stim_t load(input logic [4:0] rd);
    stim_t s = alu(rd, 5'd0, 5'd0);
    s.rs2_need = 0; s.is_load = 1;
    return s;
  endfunction

  // Busy register that EX could legally write back (not the op still in the slot).
  function automatic int pick_wb();
    int q[$];
    for (int i = 1; i < 32; i++)
      if (m_busy[i] && !(m_slot_v && m_slot_long && m_slot_rd == 5'(i))) q.push_back(i);
    if (q.size() == 0) return -1;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      stim_t s = idle();
      int r;
      if (m_busy == 0 && !m_md_busy && !m_slot_v) break;
      r = pick_wb();
      if (r > 0) begin s.wb_valid = 1; s.wb_rd = 5'(r); end
      if (m_md_busy) s.md_done = 1;
      step(s);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s = idle();
    int r, t;
    s.id_valid = ($urandom_range(0, 3) != 0);
    s.rs1 = 5'($urandom_range(0, 9)); s.rs2 = 5'($urandom_range(0, 9));
    s.rd = 5'($urandom_range(0, 9));
    s.rs1_need = 1'($urandom); s.rs2_need = 1'($urandom);
    s.rd_need = ($urandom_range(0, 4) != 0);
    t = $urandom_range(0, 9);
    s.is_load = (t == 6 || t == 7); s.is_mul = (t == 8); s.is_div = (t == 9);
    s.is_rem = (t == 5);
    s.issue_ready = ($urandom_range(0, 3) != 0);
    r = pick_wb();
    if (r > 0 && $urandom_range(0, 9) < 3) begin s.wb_valid = 1; s.wb_rd = 5'(r); end
    if (m_md_busy && $urandom_range(0, 3) == 0) s.md_done = 1;
    s.flush = ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    stim_t s;
    logic [31:0] base;
    model_reset();
    drive(idle());
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    check("rst_issue_rd", 32'(issue_rd_o), 32'd0);
    check("rst_issue_long", 32'(issue_long_o), 32'd0);
    check("rst_issue_md", 32'(issue_md_o), 32'd0);
    check("rst_stall_cnt", stall_cnt_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back independent ALU ops.
    for (int i = 0; i < 6; i++) step(alu(5'(10 + i), 5'(1 + i), 5'(2 + i)));

    // Load x5 then dependent add: stalls until writeback, released next cycle.
    step(load(5'd5));
    base = m_stall_cnt;
    for (int i = 0; i < 3; i++) step(alu(5'd12, 5'd5, 5'd3));
    s = alu(5'd12, 5'd5, 5'd3); s.wb_valid = 1; s.wb_rd = 5'd5;
    step(s);
    step(alu(5'd12, 5'd5, 5'd3));
    check("raw_stall_cycles", stall_cnt_o, base + 32'd4);
    drain();

    // mul x6 then div x7: div waits for the mul/div unit.
    s = load(5'd6); s.is_load = 0; s.is_mul = 1; step(s);
    s = load(5'd7); s.is_load = 0; s.is_div = 1;
    for (int i = 0; i < 3; i++) step(s);
    s.md_done = 1; step(s);
    s.md_done = 0; step(s);
    step(idle());
    drain();

    // Outstanding limit: four loads, fifth stalls until one writes back.
    for (int i = 1; i <= 4; i++) step(load(5'(i)));
    step(load(5'd8));
    step(load(5'd8));
    s = load(5'd8); s.wb_valid = 1; s.wb_rd = 5'd1; step(s);
    step(load(5'd8));
    s = idle(); s.wb_valid = 1; s.wb_rd = 5'd3; step(s);

    // Flush of a long op held in the slot, with a writeback on another register.
    s = load(5'd9); s.issue_ready = 0; step(s);
    s = idle(); s.issue_ready = 0; s.flush = 1; s.wb_valid = 1; s.wb_rd = 5'd2; step(s);
    step(load(5'd9));
    step(load(5'd10));
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++) step(rand_stim());
    drain();

    // Spurious writeback with nothing outstanding: sticky error.
    s = idle(); s.wb_valid = 1; s.wb_rd = 5'd3; step(s);
    for (int i = 0; i < 3; i++) step(alu(5'd4, 5'd1, 5'd2));
    s = idle(); s.md_done = 1; step(s);

    // Reset in the middle of a RAW stall.
    step(load(5'd5));
    step(alu(5'd6, 5'd5, 5'd0));
    step(alu(5'd6, 5'd5, 5'd0));
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_issue_valid", 32'(issue_valid_o), 32'd0);
    check("mid_rst_stall_cnt", stall_cnt_o, 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    check("mid_rst_cause", 32'(stall_cause_o), 32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    step(alu(5'd6, 5'd5, 5'd0));
    step(idle());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
